// File: rtl/seven_seg_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : seven_seg_scan_driver
//  Description : Tear-free, time-multiplexed driver for a common-anode
//                seven-segment display. Hex nibbles are written into pending
//                registers and copied to display registers only at frame
//                boundaries, so a digit never changes partway through a scan.
//  Ports       : i_clk      - clock, rising edge
//                i_rst      - synchronous active-high reset
//                i_wr_en    - write strobe, one cycle per write
//                i_wr_addr  - target digit (0 = rightmost)
//                i_wr_data  - hex nibble to store
//                i_blank    - 1 = all anodes off (scanning continues)
//                o_an       - anode enables, active-low, one-hot-low
//                o_seg      - segments {g,f,e,d,c,b,a}, active-low
//                o_frame    - 1-cycle pulse after the display registers update
//  Revision    : 1.0 - initial release
// ============================================================================
module seven_seg_scan_driver #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int LZ_BLANK    = 0
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_wr_en,
    input  logic [$clog2(NUM_DIGITS)-1:0] i_wr_addr,
    input  logic [3:0]                    i_wr_data,
    input  logic                          i_blank,
    output logic [NUM_DIGITS-1:0]         o_an,
    output logic [6:0]                    o_seg,
    output logic                          o_frame
);

    localparam int c_IW = $clog2(NUM_DIGITS);
    localparam int c_PW = $clog2(REFRESH_DIV);

    // Hex to active-low segment pattern, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

    logic [c_PW-1:0]       r_pre;
    logic [c_IW-1:0]       r_idx;
    logic [3:0]            r_pend [NUM_DIGITS];
    logic [3:0]            r_disp [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] r_an;
    logic [6:0]            r_seg;
    logic                  r_frame;

    logic                  w_tick;
    logic                  w_frame_end;
    logic [c_PW-1:0]       w_pre_nxt;
    logic [c_IW-1:0]       w_idx_nxt;
    logic [3:0]            w_disp_nxt [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] w_lz_blank;
    logic [3:0]            w_digit;
    logic                  w_digit_lz;
    logic [NUM_DIGITS-1:0] w_an_nxt;

    // Outputs are registered from the *next* idx/display values so that the
    // pins always reflect the state held in r_idx / r_disp after each edge.
    always_comb begin
        logic v_zero;

        w_tick      = (r_pre == c_PW'(REFRESH_DIV - 1));
        w_pre_nxt   = w_tick ? '0 : r_pre + c_PW'(1);
        w_frame_end = w_tick && (r_idx == c_IW'(NUM_DIGITS - 1));

        if (w_frame_end) begin
            w_idx_nxt = '0;
        end else if (w_tick) begin
            w_idx_nxt = r_idx + c_IW'(1);
        end else begin
            w_idx_nxt = r_idx;
        end

        // Whole frame copies pending to display in one edge.
        for (int k = 0; k < NUM_DIGITS; k++) begin
            w_disp_nxt[k] = w_frame_end ? r_pend[k] : r_disp[k];
        end

        // Walk from the most significant digit down; a digit is a leading
        // zero while it and every digit above it are zero. Digit 0 never is.
        v_zero     = 1'b1;
        w_lz_blank = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            v_zero        = v_zero && (w_disp_nxt[k] == 4'd0);
            w_lz_blank[k] = (LZ_BLANK != 0) && (k != 0) && v_zero;
        end

        w_digit    = 4'd0;
        w_digit_lz = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (w_idx_nxt == c_IW'(k)) begin
                w_digit    = w_disp_nxt[k];
                w_digit_lz = w_lz_blank[k];
            end
        end

        w_an_nxt = '1;
        if (!i_blank && !w_digit_lz) begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                if (w_idx_nxt == c_IW'(k)) begin
                    w_an_nxt[k] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pre   <= '0;
            r_idx   <= '0;
            for (int k = 0; k < NUM_DIGITS; k++) begin
                r_pend[k] <= 4'd0;
                r_disp[k] <= 4'd0;
            end
            r_an    <= '1;
            r_seg   <= 7'h7F;
            r_frame <= 1'b0;
        end else begin
            r_pre <= w_pre_nxt;
            r_idx <= w_idx_nxt;
            for (int k = 0; k < NUM_DIGITS; k++) begin
                // Addresses at or above NUM_DIGITS match no k and are dropped.
                if (i_wr_en && (i_wr_addr == c_IW'(k))) begin
                    r_pend[k] <= i_wr_data;
                end
                r_disp[k] <= w_disp_nxt[k];
            end
            r_an    <= w_an_nxt;
            r_seg   <= seg_decode(w_digit);
            r_frame <= w_frame_end;
        end
    end

    assign o_an    = r_an;
    assign o_seg   = r_seg;
    assign o_frame = r_frame;

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seven_seg_scan_driver
//  Description : Directed self-checking bench for seven_seg_scan_driver with
//                NUM_DIGITS=4, REFRESH_DIV=4; a second instance with
//                LZ_BLANK=1 shares all inputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seven_seg_scan_driver;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [1:0] wr_addr = 2'd0;
    logic [3:0] wr_data = 4'd0;
    logic       blank = 1'b0;

    logic [3:0] an,  an_lz;
    logic [6:0] seg, seg_lz;
    logic       frame, frame_lz;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    seven_seg_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4), .LZ_BLANK(0)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_wr_en(wr_en), .i_wr_addr(wr_addr),
        .i_wr_data(wr_data), .i_blank(blank), .o_an(an), .o_seg(seg), .o_frame(frame)
    );

    seven_seg_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4), .LZ_BLANK(1)) u_dut_lz (
        .i_clk(clk), .i_rst(rst), .i_wr_en(wr_en), .i_wr_addr(wr_addr),
        .i_wr_data(wr_data), .i_blank(blank), .o_an(an_lz), .o_seg(seg_lz), .o_frame(frame_lz)
    );

    // Advance n rising edges and settle 1 ns past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [3:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        step(1);
        wr_en = 1'b0;
    endtask

    task automatic test_reset;
        step(3);
        n_checks++; if (an !== 4'b1111) begin n_fail++; $display("FAIL reset_an got %b exp %b", an, 4'b1111); end
        n_checks++; if (seg !== 7'h7F) begin n_fail++; $display("FAIL reset_seg got %b exp %b", seg, 7'h7F); end
        n_checks++; if (frame !== 1'b0) begin n_fail++; $display("FAIL reset_frame got %b exp 0", frame); end
        rst = 1'b0;
        step(1);
        n_checks++; if (an !== 4'b1110) begin n_fail++; $display("FAIL release_an got %b exp %b", an, 4'b1110); end
        n_checks++; if (seg !== 7'b1000000) begin n_fail++; $display("FAIL release_seg got %b exp %b", seg, 7'b1000000); end
        step(2);
        n_checks++; if (an !== 4'b1110) begin n_fail++; $display("FAIL hold_idx0_an got %b exp %b", an, 4'b1110); end
        step(1);
        n_checks++; if (an !== 4'b1101) begin n_fail++; $display("FAIL step_idx1_an got %b exp %b", an, 4'b1101); end
    endtask

    task automatic test_write_mid_frame;
        bit ok;
        bit found;
        wr(2'd0, 4'h1);
        wr(2'd1, 4'h2);
        wr(2'd2, 4'h3);
        wr(2'd3, 4'hF);
        n_checks++; if (seg !== 7'b1000000) begin n_fail++; $display("FAIL midframe_seg got %b exp %b", seg, 7'b1000000); end
        n_checks++; if (frame !== 1'b0) begin n_fail++; $display("FAIL midframe_frame got %b exp 0", frame); end
        ok = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 24 && !found; i++) begin
            step(1);
            if (frame === 1'b1) found = 1'b1;
            else if (seg !== 7'b1000000) ok = 1'b0;
        end
        n_checks++; if (!found) begin n_fail++; $display("FAIL frame_timeout got no pulse exp pulse within 24 cycles"); end
        n_checks++; if (!ok) begin n_fail++; $display("FAIL tear_free got changed digit exp %b until frame", 7'b1000000); end
        n_checks++; if (an !== 4'b1110) begin n_fail++; $display("FAIL frame_an got %b exp %b", an, 4'b1110); end
        n_checks++; if (seg !== 7'b1111001) begin n_fail++; $display("FAIL digit0_seg got %b exp %b", seg, 7'b1111001); end
        step(1);
        n_checks++; if (frame !== 1'b0) begin n_fail++; $display("FAIL frame_width got %b exp 0", frame); end
        step(3);
        n_checks++; if (an !== 4'b1101) begin n_fail++; $display("FAIL digit1_an got %b exp %b", an, 4'b1101); end
        n_checks++; if (seg !== 7'b0100100) begin n_fail++; $display("FAIL digit1_seg got %b exp %b", seg, 7'b0100100); end
        step(4);
        n_checks++; if (seg !== 7'b0110000) begin n_fail++; $display("FAIL digit2_seg got %b exp %b", seg, 7'b0110000); end
        step(4);
        n_checks++; if (an !== 4'b0111) begin n_fail++; $display("FAIL digit3_an got %b exp %b", an, 4'b0111); end
        n_checks++; if (seg !== 7'b0001110) begin n_fail++; $display("FAIL digit3_seg got %b exp %b", seg, 7'b0001110); end
    endtask

    // Entered with idx=3, prescaler=0: the frame_end cycle is 3 cycles away.
    task automatic test_write_at_frame_end;
        step(3);
        wr(2'd2, 4'h8);
        n_checks++; if (frame !== 1'b1) begin n_fail++; $display("FAIL fe_frame got %b exp 1", frame); end
        n_checks++; if (seg !== 7'b1111001) begin n_fail++; $display("FAIL fe_digit0_seg got %b exp %b", seg, 7'b1111001); end
        step(8);
        n_checks++; if (seg !== 7'b0110000) begin n_fail++; $display("FAIL fe_not_yet_seg got %b exp %b", seg, 7'b0110000); end
        step(8);
        n_checks++; if (frame !== 1'b1) begin n_fail++; $display("FAIL fe_second_frame got %b exp 1", frame); end
        step(8);
        n_checks++; if (an !== 4'b1011) begin n_fail++; $display("FAIL fe_shown_an got %b exp %b", an, 4'b1011); end
        n_checks++; if (seg !== 7'b0000000) begin n_fail++; $display("FAIL fe_shown_seg got %b exp %b", seg, 7'b0000000); end
    endtask

    // Entered at idx=2, prescaler=0.
    task automatic test_blank;
        blank = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1);
            n_checks++; if (an !== 4'b1111) begin n_fail++; $display("FAIL blank_an cycle %0d got %b exp %b", i, an, 4'b1111); end
        end
        blank = 1'b0;
        step(1);
        n_checks++; if (an !== 4'b1110) begin n_fail++; $display("FAIL unblank_an got %b exp %b", an, 4'b1110); end
        step(1);
        n_checks++; if (an !== 4'b1101) begin n_fail++; $display("FAIL unblank_phase_an got %b exp %b", an, 4'b1101); end
    endtask

    // Entered at idx=1, prescaler=0, pending = {F,8,3,1}.
    task automatic test_reset_mid_scan;
        bit early;
        step(4);
        n_checks++; if (an !== 4'b1011) begin n_fail++; $display("FAIL prereset_an got %b exp %b", an, 4'b1011); end
        rst = 1'b1;
        step(1);
        n_checks++; if (an !== 4'b1111) begin n_fail++; $display("FAIL midrst_an got %b exp %b", an, 4'b1111); end
        n_checks++; if (seg !== 7'h7F) begin n_fail++; $display("FAIL midrst_seg got %b exp %b", seg, 7'h7F); end
        n_checks++; if (frame !== 1'b0) begin n_fail++; $display("FAIL midrst_frame got %b exp 0", frame); end
        rst = 1'b0;
        step(1);
        n_checks++; if (seg !== 7'b1000000) begin n_fail++; $display("FAIL postrst_seg got %b exp %b", seg, 7'b1000000); end
        early = 1'b0;
        for (int i = 1; i < 15; i++) begin
            step(1);
            if (frame !== 1'b0) early = 1'b1;
        end
        n_checks++; if (early) begin n_fail++; $display("FAIL postrst_early_frame got pulse exp none before full frame"); end
        step(1);
        n_checks++; if (frame !== 1'b1) begin n_fail++; $display("FAIL postrst_frame got %b exp 1", frame); end
        n_checks++; if (seg !== 7'b1000000) begin n_fail++; $display("FAIL postrst_pending_cleared got %b exp %b", seg, 7'b1000000); end
    endtask

    // Entered at a frame boundary: idx=0, prescaler=0.
    task automatic test_lz_blank;
        wr(2'd3, 4'h0);
        wr(2'd2, 4'h0);
        wr(2'd1, 4'h3);
        wr(2'd0, 4'h0);
        step(12);
        n_checks++; if (frame_lz !== 1'b1) begin n_fail++; $display("FAIL lz_frame got %b exp 1", frame_lz); end
        n_checks++; if (an_lz !== 4'b1110) begin n_fail++; $display("FAIL lz_d0_an got %b exp %b", an_lz, 4'b1110); end
        n_checks++; if (seg_lz !== 7'b1000000) begin n_fail++; $display("FAIL lz_d0_seg got %b exp %b", seg_lz, 7'b1000000); end
        step(4);
        n_checks++; if (an_lz !== 4'b1101) begin n_fail++; $display("FAIL lz_d1_an got %b exp %b", an_lz, 4'b1101); end
        n_checks++; if (seg_lz !== 7'b0110000) begin n_fail++; $display("FAIL lz_d1_seg got %b exp %b", seg_lz, 7'b0110000); end
        step(4);
        n_checks++; if (an_lz !== 4'b1111) begin n_fail++; $display("FAIL lz_d2_an got %b exp %b", an_lz, 4'b1111); end
        n_checks++; if (an !== 4'b1011) begin n_fail++; $display("FAIL nolz_d2_an got %b exp %b", an, 4'b1011); end
        step(4);
        n_checks++; if (an_lz !== 4'b1111) begin n_fail++; $display("FAIL lz_d3_an got %b exp %b", an_lz, 4'b1111); end
    endtask

    initial begin
        test_reset;
        test_write_mid_frame;
        test_write_at_frame_end;
        test_blank;
        test_reset_mid_scan;
        test_lz_blank;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
